// File: rtl/bus_arb4.sv
// Four-requester round-robin bus arbiter with a per-grant timeout.
// Each grant ends through a one-cycle RECOVER state before the arbiter returns to IDLE.
module bus_arb4 #(
  parameter logic [7:0] TO_CYCLES = 8'd255
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic [3:0] REQ,
  input  logic [3:0] DONE,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic [1:0] TO_ID
);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  state_t      state, state_nx;
  logic [1:0]  ptr;
  logic [1:0]  win;
  logic        win_vld;
  logic [7:0]  cnt;
  logic        rel_done;
  logic        rel_to;

  // Round-robin search: start at ptr, wrap 3->0, first set request wins.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!win_vld && REQ[ptr + 2'(i)]) begin
        win     = ptr + 2'(i);
        win_vld = 1'b1;
      end
    end
  end

  // DONE from the owner beats a simultaneous timeout.
  always_comb begin
    rel_done = (state == GRANT) && DONE[GNT_ID];
    rel_to   = (state == GRANT) && !rel_done &&
               (({1'b0, cnt} + 9'd1) == {1'b0, TO_CYCLES});
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_vld) state_nx = GRANT;
      GRANT:   if (rel_done || rel_to) state_nx = RECOVER;
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state   <= IDLE;
      GNT     <= 4'b0000;
      GNT_ID  <= 2'd0;
      TIMEOUT <= 1'b0;
      TO_ID   <= 2'd0;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
    end else begin
      state   <= state_nx;
      TIMEOUT <= rel_to;
      case (state)
        IDLE: if (win_vld) begin
          GNT    <= 4'b0001 << win;
          GNT_ID <= win;
          ptr    <= win + 2'd1;
          cnt    <= 8'd0;
        end
        GRANT: begin
          if (rel_done || rel_to) GNT <= 4'b0000;
          else                    cnt <= cnt + 8'd1;
          if (rel_to) TO_ID <= GNT_ID;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_bus_arb4.sv
// Directed bench for bus_arb4 built with a 4-cycle timeout.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bus_arb4;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] DONE = 4'b0000;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;
  logic       TIMEOUT;
  logic [1:0] TO_ID;

  int vec = 0;
  int miss = 0;

  bus_arb4 #(.TO_CYCLES(8'd4)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(REQ), .DONE(DONE), .GNT(GNT),
    .GNT_ID(GNT_ID), .BUSY(BUSY), .TIMEOUT(TIMEOUT), .TO_ID(TO_ID)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR_N = 1'b0;
    REQ   = 4'b0000;
    DONE  = 4'b0000;
    tick();
    CLR_N = 1'b1;
  endtask

  task automatic test_reset();
    REQ = 4'b0100;
    #2;
    vec++; if ({GNT, GNT_ID, BUSY, TIMEOUT, TO_ID} !== 10'b0)
      begin miss++; $display("FAIL reset_outs got %b want 0", {GNT, GNT_ID, BUSY, TIMEOUT, TO_ID}); end
    tick();
    vec++; if (GNT !== 4'b0000) begin miss++; $display("FAIL reset_no_grant1 got %b want 0000", GNT); end
    tick();
    vec++; if (GNT !== 4'b0000) begin miss++; $display("FAIL reset_no_grant2 got %b want 0000", GNT); end
    REQ   = 4'b0000;
    CLR_N = 1'b1;
    tick();
    vec++; if (BUSY !== 1'b0) begin miss++; $display("FAIL reset_idle_busy got %b want 0", BUSY); end
  endtask

  task automatic test_basic();
    REQ = 4'b0101;
    tick();
    vec++; if (GNT !== 4'b0001 || GNT_ID !== 2'd0 || BUSY !== 1'b1)
      begin miss++; $display("FAIL basic_first got gnt=%b id=%0d busy=%b want 0001/0/1", GNT, GNT_ID, BUSY); end
    DONE = 4'b0001;
    tick();
    DONE = 4'b0000;
    vec++; if (GNT !== 4'b0000 || BUSY !== 1'b1)
      begin miss++; $display("FAIL basic_recover got gnt=%b busy=%b want 0000/1", GNT, BUSY); end
    tick();
    vec++; if (GNT !== 4'b0000 || BUSY !== 1'b0)
      begin miss++; $display("FAIL basic_idle got gnt=%b busy=%b want 0000/0", GNT, BUSY); end
    tick();
    vec++; if (GNT !== 4'b0100 || GNT_ID !== 2'd2)
      begin miss++; $display("FAIL basic_second got gnt=%b id=%0d want 0100/2", GNT, GNT_ID); end
    DONE = 4'b0100;
    REQ  = 4'b0000;
    tick();
    DONE = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      vec++; if (GNT !== (4'b0001 << order[k]) || GNT_ID !== order[k])
        begin miss++; $display("FAIL rr_grant%0d got gnt=%b id=%0d want id %0d", k, GNT, GNT_ID, order[k]); end
      DONE = GNT;
      tick();
      DONE = 4'b0000;
      vec++; if (GNT !== 4'b0000) begin miss++; $display("FAIL rr_gap_a%0d got %b want 0000", k, GNT); end
      tick();
      vec++; if (GNT !== 4'b0000) begin miss++; $display("FAIL rr_gap_b%0d got %b want 0000", k, GNT); end
    end
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    REQ = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      vec++; if (GNT !== 4'b1000 || TIMEOUT !== 1'b0)
        begin miss++; $display("FAIL to_hold%0d got gnt=%b to=%b want 1000/0", k, GNT, TIMEOUT); end
    end
    tick();
    vec++; if (GNT !== 4'b0000 || TIMEOUT !== 1'b1 || TO_ID !== 2'd3 || BUSY !== 1'b1)
      begin miss++; $display("FAIL to_fire got gnt=%b to=%b toid=%0d busy=%b want 0000/1/3/1", GNT, TIMEOUT, TO_ID, BUSY); end
    tick();
    vec++; if (GNT !== 4'b0000 || TIMEOUT !== 1'b0 || TO_ID !== 2'd3)
      begin miss++; $display("FAIL to_idle got gnt=%b to=%b toid=%0d want 0000/0/3", GNT, TIMEOUT, TO_ID); end
    tick();
    vec++; if (GNT !== 4'b1000) begin miss++; $display("FAIL to_regrant got %b want 1000", GNT); end
    REQ  = 4'b0000;
    DONE = 4'b1000;
    tick();
    DONE = 4'b0000;
    tick();
  endtask

  task automatic test_done_wins();
    REQ = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    vec++; if (GNT !== 4'b0001) begin miss++; $display("FAIL dw_hold got %b want 0001", GNT); end
    DONE = 4'b0001;
    tick();
    DONE = 4'b0000;
    REQ  = 4'b0000;
    vec++; if (GNT !== 4'b0000 || TIMEOUT !== 1'b0 || TO_ID !== 2'd3)
      begin miss++; $display("FAIL dw_release got gnt=%b to=%b toid=%0d want 0000/0/3", GNT, TIMEOUT, TO_ID); end
    tick();
    vec++; if (TIMEOUT !== 1'b0) begin miss++; $display("FAIL dw_no_pulse got %b want 0", TIMEOUT); end
  endtask

  task automatic test_async_reset();
    REQ = 4'b0001;
    tick();
    vec++; if (GNT !== 4'b0001) begin miss++; $display("FAIL ar_pre got %b want 0001", GNT); end
    #2 CLR_N = 1'b0;
    #1;
    vec++; if (GNT !== 4'b0000 || BUSY !== 1'b0 || TO_ID !== 2'd0)
      begin miss++; $display("FAIL ar_immediate got gnt=%b busy=%b toid=%0d want 0000/0/0", GNT, BUSY, TO_ID); end
    REQ = 4'b0011;
    #1 CLR_N = 1'b1;
    tick();
    vec++; if (GNT !== 4'b0001 || GNT_ID !== 2'd0)
      begin miss++; $display("FAIL ar_ptr_restart got gnt=%b id=%0d want 0001/0", GNT, GNT_ID); end
    REQ  = 4'b0000;
    DONE = 4'b0001;
    tick();
    DONE = 4'b0000;
    tick();
  endtask

  task automatic test_non_owner_done();
    do_reset();
    REQ = 4'b0010;
    tick();
    vec++; if (GNT !== 4'b0010) begin miss++; $display("FAIL no_grant got %b want 0010", GNT); end
    DONE = 4'b1101;
    tick();
    DONE = 4'b0000;
    REQ  = 4'b0000;
    vec++; if (GNT !== 4'b0010 || TIMEOUT !== 1'b0)
      begin miss++; $display("FAIL no_ignore got gnt=%b to=%b want 0010/0", GNT, TIMEOUT); end
    tick();
    vec++; if (GNT !== 4'b0010) begin miss++; $display("FAIL no_req_drop got %b want 0010", GNT); end
    DONE = 4'b0010;
    tick();
    DONE = 4'b0000;
    vec++; if (GNT !== 4'b0000 || BUSY !== 1'b1)
      begin miss++; $display("FAIL no_release got gnt=%b busy=%b want 0000/1", GNT, BUSY); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_done_wins();
    test_async_reset();
    test_non_owner_done();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arb4.md
BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 8'd255: grant cycles allowed before a forced release (range 1..255).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 SHALL have port CLR_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port REQ  input  4  request per requester, level-sensitive, bit i = requester i.
REQ-005 SHALL have port DONE  input  4  release strobe per requester; honoured only from the current owner.
REQ-006 SHALL have port GNT  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 SHALL have port GNT_ID  output  2  index of the current owner; holds last owner when GNT=0.
REQ-008 SHALL have port BUSY  output  1  high in GRANT and RECOVER states.
REQ-009 SHALL have port TIMEOUT  output  1  one-cycle pulse on forced release.
REQ-010 SHALL have port TO_ID  output  2  owner index at the last forced release; sticky until next timeout or reset.

Function
REQ-011 SHALL implement three states: IDLE, GRANT, RECOVER.
REQ-012 IDLE: REQ=0 -> stay IDLE; REQ!=0 -> pick winner, go GRANT; GNT asserted in the cycle after REQ is sampled (latency 1).
REQ-013 Winner selection SHALL be round-robin: search starts at PTR, wraps 3->0, and the first set REQ bit wins.
REQ-014 On entering GRANT, PTR SHALL load (winner+1) mod 4; PTR resets to 0.
REQ-015 GRANT: GNT[owner]=1; only DONE[owner] releases; DONE bits of non-owners SHALL be ignored with no side effect.
REQ-016 Owner dropping REQ without DONE SHALL NOT release; the grant holds until DONE or timeout.
REQ-017 The 8-bit timeout counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-018 When the counter reaches TO_CYCLES with no DONE[owner], the block SHALL force release: pulse TIMEOUT, load TO_ID=owner, go RECOVER.
REQ-019 If DONE[owner] arrives in the same cycle as the timeout condition, DONE SHALL win: no TIMEOUT pulse, TO_ID unchanged.
REQ-020 Release by DONE or timeout SHALL clear GNT at the next edge and enter RECOVER.
REQ-021 RECOVER SHALL last exactly one cycle with GNT=0 and BUSY=1, then return to IDLE; REQ is not sampled in RECOVER.
REQ-022 Back-to-back sequence SHALL be GRANT(A) -> RECOVER -> IDLE -> GRANT(B); the minimum gap between grants is 2 cycles of GNT=0.
REQ-023 An owner still holding REQ after release SHALL take lowest priority through PTR; it is not blocked otherwise.
REQ-024 GNT SHALL never have more than one bit set in any cycle.

Reset
REQ-025 CLR_N=0 SHALL immediately force: state IDLE, GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0, TO_ID=0, PTR=0, counter=0, regardless of CLK.
REQ-026 Reset during GRANT SHALL drop GNT within the same cycle (asynchronous); after CLR_N rises, the first posedge samples in IDLE.
REQ-027 No grant SHALL occur on the posedge on which CLR_N is still low.

Verification
REQ-028 Reset, then REQ=4'b0101 held -> GNT=0001 at cycle+1; DONE=0001 -> two cycles of GNT=0 -> GNT=0100, GNT_ID=2.
REQ-029 REQ=4'b1111 held, each owner pulses DONE one cycle after grant -> grant order 0,1,2,3,0; GNT is always one-hot.
REQ-030 TO_CYCLES=4, REQ=4'b1000, no DONE -> GNT=1000 for 4 cycles, TIMEOUT pulses once, TO_ID=3, GNT=0, then regrant of 3 after RECOVER and IDLE.
REQ-031 Owner 1 granted, DONE=4'b1101 (non-owners only) -> no release; owner drops REQ -> GNT stays 0010 until DONE[1].
REQ-032 TO_CYCLES=4, DONE[owner] on the timeout cycle -> release, TIMEOUT=0, TO_ID unchanged.
REQ-033 CLR_N pulsed low mid-GRANT between clock edges -> GNT=0 and BUSY=0 immediately; after release, REQ=0010 -> GNT=0010 (PTR restarted at 0).
